// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 keyboard frame receiver with a scan-code FIFO.
// Pins are synchronised, falling edges of the PS/2 clock shift frame bits
// into an 11-bit register, and each complete frame is checked (start, stop,
// odd parity) before its data byte is queued for the bus to pop.
module ps2_keyboard_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic       readEnable,
  input  logic       clearError,
  output logic [7:0] scanCode,
  output logic       dataValid,
  output logic       overflow,
  output logic       frameError,
  output logic       interrupt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  // Frame layout after 11 right-shifts: [0] start, [8:1] data, [9] parity, [10] stop.
  function automatic logic frame_ok(input logic [10:0] frame);
    logic parity_ok;
    parity_ok = ((^frame[9:1]) == 1'b1);
    frame_ok  = (frame[0] == 1'b0) && (frame[10] == 1'b1) && parity_ok;
  endfunction

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic              ps2clk_meta_q,  ps2clk_meta_d;
  logic              ps2clk_sync_q,  ps2clk_sync_d;
  logic              ps2clk_prev_q,  ps2clk_prev_d;
  logic              ps2data_meta_q, ps2data_meta_d;
  logic              ps2data_sync_q, ps2data_sync_d;

  state_e            state_q,   state_d;
  logic [10:0]       shift_q,   shift_d;
  logic [3:0]        bitcnt_q,  bitcnt_d;
  logic [TO_W-1:0]   timeout_q, timeout_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [7:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
  logic [CNT_W-1:0]  count_q,   count_d;

  logic [7:0]        scan_code_q,   scan_code_d;
  logic              data_valid_q,  data_valid_d;
  logic              overflow_q,    overflow_d;
  logic              frame_error_q, frame_error_d;

  // Decoded strobes
  logic              fall_edge_s;
  logic              bit_s;
  logic              check_s;
  logic              frame_valid_s;
  logic              full_s;
  logic              empty_s;
  logic              pop_s;
  logic              push_s;
  logic              ovf_set_s;
  logic              ferr_set_s;

  // ------------------------------------------------------------------
  // Input synchronisers and edge detect
  // ------------------------------------------------------------------

  // Next values of the synchroniser chain: two stages per pin, one extra
  // clock stage so the previous synced level is available for edge detect.
  always_comb begin
    ps2clk_meta_d  = ps2clk;
    ps2clk_sync_d  = ps2clk_meta_q;
    ps2clk_prev_d  = ps2clk_sync_q;
    ps2data_meta_d = ps2data;
    ps2data_sync_d = ps2data_meta_q;
  end

  // Synchroniser registers; cleared so no false falling edge follows reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ps2clk_meta_q  <= 1'b0;
      ps2clk_sync_q  <= 1'b0;
      ps2clk_prev_q  <= 1'b0;
      ps2data_meta_q <= 1'b0;
      ps2data_sync_q <= 1'b0;
    end else begin
      ps2clk_meta_q  <= ps2clk_meta_d;
      ps2clk_sync_q  <= ps2clk_sync_d;
      ps2clk_prev_q  <= ps2clk_prev_d;
      ps2data_meta_q <= ps2data_meta_d;
      ps2data_sync_q <= ps2data_sync_d;
    end
  end

  assign fall_edge_s = ps2clk_prev_q & ~ps2clk_sync_q;
  assign bit_s       = ps2data_sync_q;

  // ------------------------------------------------------------------
  // Frame receive FSM
  // ------------------------------------------------------------------

  // Next-state logic: hunt for a start bit, shift 11 bits, check for one cycle.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    timeout_d = timeout_q;
    check_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timeout_d = '0;
        if (fall_edge_s && (bit_s == 1'b0)) begin
          state_d  = ST_RECV;
          shift_d  = {bit_s, 10'd0};
          bitcnt_d = 4'd1;
        end else begin
          state_d  = ST_IDLE;
          bitcnt_d = 4'd0;
        end
      end
      ST_RECV: begin
        if (fall_edge_s) begin
          shift_d   = {bit_s, shift_q[10:1]};
          bitcnt_d  = bitcnt_q + 4'd1;
          timeout_d = '0;
          if (bitcnt_q == 4'd10) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_RECV;
          end
        end else if (timeout_q >= TO_LAST) begin
          // Stalled sender: abandon the partial frame without flagging it.
          state_d   = ST_IDLE;
          shift_d   = 11'd0;
          bitcnt_d  = 4'd0;
          timeout_d = '0;
        end else begin
          timeout_d = timeout_q + TO_W'(1);
        end
      end
      ST_CHECK: begin
        check_s   = 1'b1;
        state_d   = ST_IDLE;
        bitcnt_d  = 4'd0;
        timeout_d = '0;
      end
      default: begin
        state_d   = ST_IDLE;
        shift_d   = 11'd0;
        bitcnt_d  = 4'd0;
        timeout_d = '0;
      end
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= 11'd0;
      bitcnt_q  <= 4'd0;
      timeout_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      timeout_q <= timeout_d;
    end
  end

  // ------------------------------------------------------------------
  // Frame check and FIFO control
  // ------------------------------------------------------------------
  assign frame_valid_s = frame_ok(shift_q);
  assign full_s        = (count_q == FULL_CNT);
  assign empty_s       = (count_q == {CNT_W{1'b0}});
  assign pop_s         = readEnable & ~empty_s;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_s        = check_s & frame_valid_s & (~full_s | pop_s);
  assign ovf_set_s     = check_s & frame_valid_s & full_s & ~pop_s;
  assign ferr_set_s    = check_s & ~frame_valid_s;

  // FIFO pointers, occupancy, storage and the registered head/flag outputs.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end

    if (push_s) begin
      mem_d[wr_ptr_q] = shift_q[8:1];
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Head of the queue after this edge; a byte pushed into the head slot
    // bypasses storage so it is visible on the same edge it is written.
    data_valid_d = (count_d != {CNT_W{1'b0}});
    if (!data_valid_d) begin
      scan_code_d = 8'h00;
    end else if (push_s && (rd_ptr_d == wr_ptr_q)) begin
      scan_code_d = shift_q[8:1];
    end else begin
      scan_code_d = mem_q[rd_ptr_d];
    end

    // Sticky flags: a new error in the same cycle beats clearError.
    if (ovf_set_s) begin
      overflow_d = 1'b1;
    end else if (clearError) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    if (ferr_set_s) begin
      frame_error_d = 1'b1;
    end else if (clearError) begin
      frame_error_d = 1'b0;
    end else begin
      frame_error_d = frame_error_q;
    end
  end

  // FIFO and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      scan_code_q   <= 8'h00;
      data_valid_q  <= 1'b0;
      overflow_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      scan_code_q   <= scan_code_d;
      data_valid_q  <= data_valid_d;
      overflow_q    <= overflow_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign scanCode   = scan_code_q;
  assign dataValid  = data_valid_q;
  assign interrupt  = data_valid_q;
  assign overflow   = overflow_q;
  assign frameError = frame_error_q;

endmodule
